// File: rtl/decompressor8.sv
// decompressor8: buffered word-to-wires expander.
// Accepts 8-bit words over valid/ready into a 2-entry FIFO and drives the
// head word as eight flop-driven single-bit outputs. Each head word is held
// for at least HOLD cycles before out_valid asserts. The consumer
// acknowledges each word with out_valid/out_ready.
// Optional feature: define DECOMP8_PARITY_EN to add the in_par input and the
// sticky par_err output. Words that fail the even-parity check complete
// their handshake but are not stored.
module decompressor8 #(
  parameter int unsigned HOLD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       o0,
  output logic       o1,
  output logic       o2,
  output logic       o3,
  output logic       o4,
  output logic       o5,
  output logic       o6,
  output logic       o7,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] level
`ifdef DECOMP8_PARITY_EN
  ,
  input  logic       in_par,
  output logic       par_err
`endif
);

  localparam logic [3:0] HOLD_MAX = 4'(HOLD - 1);

  logic [7:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [7:0] head_q;
  logic [3:0] hold_cnt;
  logic       handshake;
  logic       push;
  logic       pop;
  logic       head_load;
  logic [7:0] head_next;

  // A full FIFO refuses words even when a pop happens on the same edge.
  assign in_ready  = (count != 2'd2) && !rst;
  assign out_valid = (count != 2'd0) && (hold_cnt == HOLD_MAX);
  assign handshake = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = count;

`ifdef DECOMP8_PARITY_EN
  // A bad-parity word still completes its handshake but is never stored.
  assign push = handshake && !(^{in, in_par});
`else
  assign push = handshake;
`endif

  assign {o7, o6, o5, o4, o3, o2, o1, o0} = head_q;

  // Work out whether a different word becomes head on the next edge and which one.
  always_comb begin
    head_load = 1'b0;
    head_next = head_q;
    if (pop && (count == 2'd2)) begin
      head_load = 1'b1;
      head_next = mem[~rd_ptr];
    end else if (push && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
      head_load = 1'b1;
      head_next = in;
    end
  end

  // FIFO storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= 8'h00;
      mem[1] <= 8'h00;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head output register: it keeps the last head when the FIFO drains, and the hold timer restarts for every new head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= 8'h00;
      hold_cnt <= 4'd0;
    end else if (head_load) begin
      head_q   <= head_next;
      hold_cnt <= 4'd0;
    end else if ((count != 2'd0) && (hold_cnt != HOLD_MAX)) begin
      hold_cnt <= hold_cnt + 4'd1;
    end
  end

`ifdef DECOMP8_PARITY_EN
  // Sticky flag for any handshake whose word failed the even-parity check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err <= 1'b0;
    end else if (handshake && (^{in, in_par})) begin
      par_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_decompressor8.sv
// Testbench for decompressor8: drives a HOLD=1 and a HOLD=4 instance with
// directed vectors. Expected words go into per-instance queues, and negedge
// monitors compare each word the DUT delivers.
module tb_decompressor8;

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] in1, ob1;
  logic       in_valid1, in_ready1, ov1, or1;
  logic [1:0] lvl1;
  logic [7:0] in4, ob4;
  logic       in_valid4, in_ready4, ov4, or4;
  logic [1:0] lvl4;
`ifdef DECOMP8_PARITY_EN
  logic       in_par1, par_err1, in_par4, par_err4;
`endif

  logic [7:0] q1[$];
  logic [7:0] q4[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decompressor8 #(.HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .in(in1), .in_valid(in_valid1), .in_ready(in_ready1),
    .o0(ob1[0]), .o1(ob1[1]), .o2(ob1[2]), .o3(ob1[3]),
    .o4(ob1[4]), .o5(ob1[5]), .o6(ob1[6]), .o7(ob1[7]),
    .out_valid(ov1), .out_ready(or1), .level(lvl1)
`ifdef DECOMP8_PARITY_EN
    , .in_par(in_par1), .par_err(par_err1)
`endif
  );

  decompressor8 #(.HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .in(in4), .in_valid(in_valid4), .in_ready(in_ready4),
    .o0(ob4[0]), .o1(ob4[1]), .o2(ob4[2]), .o3(ob4[3]),
    .o4(ob4[4]), .o5(ob4[5]), .o6(ob4[6]), .o7(ob4[7]),
    .out_valid(ov4), .out_ready(or4), .level(lvl4)
`ifdef DECOMP8_PARITY_EN
    , .in_par(in_par4), .par_err(par_err4)
`endif
  );

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // sel 0 drives the HOLD=1 instance and sel 1 drives the HOLD=4 instance; a word expected to be delivered is queued.
  task automatic applyStimulus(input logic sel, input logic [7:0] word, input logic valid, input logic expect_push);
    if (!sel) begin
      in1 = word;
      in_valid1 = valid;
`ifdef DECOMP8_PARITY_EN
      in_par1 = ^word;
`endif
      if (expect_push) q1.push_back(word);
    end else begin
      in4 = word;
      in_valid4 = valid;
`ifdef DECOMP8_PARITY_EN
      in_par4 = ^word;
`endif
      if (expect_push) q4.push_back(word);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for the HOLD=1 instance.
  always @(negedge clk) begin
    if (ov1 && or1) begin
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL sb1_unexpected: got %h, required no word", ob1);
      end else begin
        checkOutput("sb1_word", ob1, q1.pop_front());
      end
    end
  end

  // Scoreboard monitor for the HOLD=4 instance.
  always @(negedge clk) begin
    if (ov4 && or4) begin
      if (q4.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL sb4_unexpected: got %h, required no word", ob4);
      end else begin
        checkOutput("sb4_word", ob4, q4.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    or1 = 1'b0;
    or4 = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    repeat (2) step();
    @(negedge clk);
    checkOutput("rst_o", ob1, 8'h00);
    checkOutput("rst_valid", 8'(ov1), 8'h00);
    checkOutput("rst_level", 8'(lvl1), 8'h00);
    checkOutput("rst_in_ready", 8'(in_ready1), 8'h00);
    step();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rel_in_ready", 8'(in_ready1), 8'h01);

    // HOLD=1 streaming
    or1 = 1'b1;
    applyStimulus(1'b0, 8'hA5, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 8'h3C, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("str_a5", ob1, 8'hA5);
    checkOutput("str_a5_valid", 8'(ov1), 8'h01);
    checkOutput("str_level", 8'(lvl1), 8'h01);
    step();
    applyStimulus(1'b0, 8'hFF, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("str_3c", ob1, 8'h3C);
    checkOutput("str_3c_valid", 8'(ov1), 8'h01);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("str_ff", ob1, 8'hFF);
    checkOutput("str_ff_valid", 8'(ov1), 8'h01);
    step();
    @(negedge clk);
    checkOutput("drain_level", 8'(lvl1), 8'h00);
    checkOutput("drain_valid", 8'(ov1), 8'h00);
    checkOutput("drain_keep", ob1, 8'hFF);

    // Backpressure
    or1 = 1'b0;
    applyStimulus(1'b0, 8'h11, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 8'h22, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 8'h33, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("bp_in_ready", 8'(in_ready1), 8'h00);
    checkOutput("bp_level", 8'(lvl1), 8'h02);
    checkOutput("bp_head", ob1, 8'h11);
    step();
    or1 = 1'b1;
    @(negedge clk);
    checkOutput("bp_full_hold", 8'(lvl1), 8'h02);
    step();
    @(negedge clk);
    checkOutput("bp_ready_back", 8'(in_ready1), 8'h01);
    checkOutput("bp_level1", 8'(lvl1), 8'h01);
    checkOutput("bp_head2", ob1, 8'h22);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp_head3", ob1, 8'h33);
    checkOutput("bp_level_pp", 8'(lvl1), 8'h01);
    step();
    @(negedge clk);
    checkOutput("bp_drain", 8'(lvl1), 8'h00);

    // Level-1 push and pop in the same cycle
    or1 = 1'b0;
    applyStimulus(1'b0, 8'h01, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 8'h02, 1'b1, 1'b1);
    or1 = 1'b1;
    @(negedge clk);
    checkOutput("l1_head01", ob1, 8'h01);
    checkOutput("l1_valid", 8'(ov1), 8'h01);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("l1_o1", 8'(ob1[1]), 8'h01);
    checkOutput("l1_o0", 8'(ob1[0]), 8'h00);
    checkOutput("l1_level", 8'(lvl1), 8'h01);
    step();
    @(negedge clk);
    checkOutput("l1_drain", 8'(lvl1), 8'h00);

`ifdef DECOMP8_PARITY_EN
    // Parity: a bad word is handshaken but dropped; the error flag is sticky
    applyStimulus(1'b0, 8'h07, 1'b1, 1'b0);
    in_par1 = 1'b0;
    @(negedge clk);
    checkOutput("par_bad_ready", 8'(in_ready1), 8'h01);
    checkOutput("par_clear", 8'(par_err1), 8'h00);
    step();
    applyStimulus(1'b0, 8'h07, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("par_err_set", 8'(par_err1), 8'h01);
    checkOutput("par_dropped", 8'(lvl1), 8'h00);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("par_good_head", ob1, 8'h07);
    checkOutput("par_good_level", 8'(lvl1), 8'h01);
    checkOutput("par_sticky", 8'(par_err1), 8'h01);
    step();
`endif

    // Asynchronous reset with a full FIFO
    or1 = 1'b0;
    applyStimulus(1'b0, 8'hAA, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 8'h55, 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ar_full", 8'(lvl1), 8'h02);
    @(posedge clk);
    #2;
    rst = 1'b1;
    q1.delete();
    q4.delete();
    #1;
    checkOutput("ar_o", ob1, 8'h00);
    checkOutput("ar_valid", 8'(ov1), 8'h00);
    checkOutput("ar_level", 8'(lvl1), 8'h00);
    checkOutput("ar_in_ready", 8'(in_ready1), 8'h00);
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ar_rel_ready", 8'(in_ready1), 8'h01);

    // HOLD=4 instance
    or4 = 1'b1;
    applyStimulus(1'b1, 8'h81, 1'b1, 1'b1);
    step();
    applyStimulus(1'b1, 8'h42, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("h4_o0", 8'(ob4[0]), 8'h01);
    checkOutput("h4_o7", 8'(ob4[7]), 8'h01);
    checkOutput("h4_valid_c0", 8'(ov4), 8'h00);
    step();
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("h4_valid_c1", 8'(ov4), 8'h00);
    checkOutput("h4_level2", 8'(lvl4), 8'h02);
    step();
    @(negedge clk);
    checkOutput("h4_valid_c2", 8'(ov4), 8'h00);
    step();
    @(negedge clk);
    checkOutput("h4_valid_c3", 8'(ov4), 8'h01);
    checkOutput("h4_head81", ob4, 8'h81);
    step();
    @(negedge clk);
    checkOutput("h4_restart", 8'(ov4), 8'h00);
    checkOutput("h4_head42", ob4, 8'h42);
    checkOutput("h4_level1", 8'(lvl4), 8'h01);
    step();
    @(negedge clk);
    checkOutput("h4_r_c1", 8'(ov4), 8'h00);
    step();
    @(negedge clk);
    checkOutput("h4_r_c2", 8'(ov4), 8'h00);
    step();
    @(negedge clk);
    checkOutput("h4_r_c3", 8'(ov4), 8'h01);
    step();
    @(negedge clk);
    checkOutput("h4_drain", 8'(lvl4), 8'h00);

    checkOutput("sb1_empty", 8'(q1.size()), 8'h00);
    checkOutput("sb4_empty", 8'(q4.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
